// File: rtl/prop_mem_responder_if.sv
// ============================================================================
// Module : prop_mem_responder_if
// Brief  : Request/write/response bundle between the read stage and the
//          property memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prop_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic [63:0]       rsp_data;
    logic              rsp_complete;
    logic              busy;

    modport master (
        output req_valid, req_addr, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_data, rsp_complete, busy
    );

    modport slave (
        input  req_valid, req_addr, wr_en, wr_addr, wr_data,
        output req_ready, rsp_data, rsp_complete, busy
    );
endinterface

`default_nettype wire

// File: rtl/prop_mem_responder.sv
// ============================================================================
// Module : prop_mem_responder
// Brief  : Queued fixed-latency read responder over a 64-bit property store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prop_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    prop_mem_responder_if.slave  bus
);
    localparam int              c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int              c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_fifo_full = c_cnt_w'(FIFO_DEPTH);
    localparam logic [3:0]      c_lat_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [63:0]        r_mem  [DEPTH];
    logic [ADDR_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_wait_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [63:0]        r_rsp_data;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;

    // Ready looks only at registered occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_ready = (r_count < c_fifo_full);
    assign w_push  = bus.req_valid & w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_rsp_data <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_fifo[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_wait_cnt <= c_lat_init;
            end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            // Non-blocking read of the array gives pre-write data on a
            // same-edge write to the captured address.
            if (w_capture) begin
                r_rsp_data <= r_mem[r_addr];
            end
        end
    end

    // Storage arrays carry no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.req_addr;
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_complete = (r_state == S_RESP);
    assign bus.busy         = (r_count != '0) || (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_prop_mem_responder.sv
// ============================================================================
// Module : tb_prop_mem_responder
// Brief  : Self-checking bench for prop_mem_responder (LATENCY 4 and 1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prop_mem_responder;
    localparam int LAT = 4;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] exp;
        bit          drain;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    int   n_rsp;
    int   last_done;
    exp_t sb[$];
    vec_t tbl[9];

    prop_mem_responder_if #(.ADDR_W(8)) bus0 ();
    prop_mem_responder_if #(.ADDR_W(8)) bus1 ();

    prop_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(LAT), .FIFO_DEPTH(4)) dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    prop_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1), .FIFO_DEPTH(4)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus0.rsp_complete) begin
            exp_t e;
            n_rsp++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%h required=none (cycle %0d)",
                         bus0.rsp_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", bus0.rsp_data, e.data);
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wr_both(input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        bus0.wr_en = 1'b1; bus0.wr_addr = a; bus0.wr_data = d;
        bus1.wr_en = 1'b1; bus1.wr_addr = a; bus1.wr_data = d;
    endtask

    task automatic wr_off();
        @(negedge clk);
        bus0.wr_en = 1'b0;
        bus1.wr_en = 1'b0;
    endtask

    // Completion cycle: pop one edge after acceptance or two after the
    // previous completion, whichever is later, then LAT cycles of service.
    task automatic issue(input logic [7:0] a, input logic [63:0] e, input bit must);
        int   k;
        int   p;
        exp_t x;
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_addr  = a;
        chk("req_ready", {63'd0, bus0.req_ready}, {63'd0, must});
        if (bus0.req_ready) begin
            k         = cyc + 1;
            p         = (k + 1 > last_done + 2) ? k + 1 : last_done + 2;
            x.cyc     = p + LAT;
            x.data    = e;
            last_done = x.cyc;
            sb.push_back(x);
        end
    endtask

    task automatic req_off();
        @(negedge clk);
        bus0.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          pulses;
        int          at_cyc;
        int          nb;
        logic [63:0] d;
        logic [63:0] va;
        logic [63:0] vb;

        checks = 0; failures = 0; n_rsp = 0; cyc = 0; last_done = -100;
        rst = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_addr = '0;
        bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
        bus1.req_valid = 1'b0; bus1.req_addr = '0;
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;

        tbl[0] = '{8'd5,  64'hDEAD_BEEF_0000_0005, 1'b1};
        tbl[1] = '{8'd1,  64'hDEAD_BEEF_0000_0001, 1'b1};
        tbl[2] = '{8'd2,  64'hDEAD_BEEF_0000_0002, 1'b0};
        tbl[3] = '{8'd3,  64'hDEAD_BEEF_0000_0003, 1'b0};
        tbl[4] = '{8'd4,  64'hDEAD_BEEF_0000_0004, 1'b0};
        tbl[5] = '{8'd5,  64'hDEAD_BEEF_0000_0005, 1'b0};
        tbl[6] = '{8'd15, 64'hDEAD_BEEF_0000_000F, 1'b1};
        tbl[7] = '{8'd0,  64'hDEAD_BEEF_0000_0000, 1'b0};
        tbl[8] = '{8'd8,  64'hDEAD_BEEF_0000_0008, 1'b0};

        // Reset state, with a request held during reset.
        #3;
        chk("rst_ready", {63'd0, bus0.req_ready}, 64'd1);
        chk("rst_busy", {63'd0, bus0.busy}, 64'd0);
        chk("rst_complete", {63'd0, bus0.rsp_complete}, 64'd0);
        chk("rst_data", bus0.rsp_data, 64'd0);
        bus0.req_valid = 1'b1; bus0.req_addr = 8'd5;
        repeat (3) @(negedge clk);
        chk("rst_hold_ready", {63'd0, bus0.req_ready}, 64'd1);
        chk("rst_hold_busy", {63'd0, bus0.busy}, 64'd0);
        bus0.req_valid = 1'b0;
        #2 rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            wr_both(8'(i), 64'hDEAD_BEEF_0000_0000 | 64'(i));
        end
        wr_off();
        repeat (2) @(negedge clk);
        chk("idle_busy", {63'd0, bus0.busy}, 64'd0);

        // Table: single latency, five back-to-back into a 4-deep queue, more.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].drain) begin
                req_off();
                wait_drain();
            end
            issue(tbl[i].addr, tbl[i].exp, 1'b1);
        end
        req_off();
        wait_drain();

        // Full queue: the request for 9 is refused and never answered.
        for (int i = 10; i < 15; i++) begin
            issue(8'(i), 64'hDEAD_BEEF_0000_0000 | 64'(i), 1'b1);
        end
        issue(8'd9, 64'd0, 1'b0);
        issue(8'd9, 64'd0, 1'b0);
        req_off();
        wait_drain();
        repeat (10) @(negedge clk);

        // Write to the captured address on the capture edge.
        va = 64'hAAAA_0000_1111_0007;
        vb = 64'hBBBB_0000_2222_0007;
        wr_both(8'd7, va);
        wr_off();
        issue(8'd7, va, 1'b1);
        c0 = cyc;
        req_off();
        while (cyc < c0 + 5) @(negedge clk);
        bus0.wr_en = 1'b1; bus0.wr_addr = 8'd7; bus0.wr_data = vb;
        @(negedge clk);
        bus0.wr_en = 1'b0;
        wait_drain();
        issue(8'd7, vb, 1'b1);
        req_off();
        wait_drain();
        repeat (4) @(negedge clk);
        chk("rsp_data_hold", bus0.rsp_data, vb);

        // Reset while in WAIT with two requests queued.
        issue(8'd1, 64'hDEAD_BEEF_0000_0001, 1'b1);
        issue(8'd2, 64'hDEAD_BEEF_0000_0002, 1'b1);
        issue(8'd3, 64'hDEAD_BEEF_0000_0003, 1'b1);
        req_off();
        @(negedge clk);
        chk("pre_rst_busy", {63'd0, bus0.busy}, 64'd1);
        #2 rst = 1'b1;
        sb.delete();
        last_done = -100;
        #1;
        chk("async_rst_data", bus0.rsp_data, 64'd0);
        chk("async_rst_busy", {63'd0, bus0.busy}, 64'd0);
        chk("async_rst_complete", {63'd0, bus0.rsp_complete}, 64'd0);
        chk("async_rst_ready", {63'd0, bus0.req_ready}, 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        nb = n_rsp;
        repeat (20) @(negedge clk);
        chk("post_rst_rsp_count", 64'(n_rsp), 64'(nb));
        chk("post_rst_busy", {63'd0, bus0.busy}, 64'd0);

        // Memory survives reset.
        issue(8'd5, 64'hDEAD_BEEF_0000_0005, 1'b1);
        req_off();
        wait_drain();

        // LATENCY=1 instance: one pulse, two cycles after acceptance.
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 8'd3;
        chk("l1_ready", {63'd0, bus1.req_ready}, 64'd1);
        c0 = cyc;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        pulses = 0; at_cyc = -1; d = '0;
        repeat (8) begin
            if (bus1.rsp_complete) begin
                pulses++;
                at_cyc = cyc;
                d = bus1.rsp_data;
            end
            @(negedge clk);
        end
        chk("l1_pulses", 64'(pulses), 64'd1);
        chk("l1_cycle", 64'(at_cyc), 64'(c0 + 3));
        chk("l1_data", d, 64'hDEAD_BEEF_0000_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
